// File: rtl/gp_pkg.sv
// Shared types and default sizing for the command scheduler.
package gp_pkg;

  localparam int unsigned DefPktBits       = 56;
  localparam int unsigned DefFifoDepth     = 4;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone
  } sched_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on rdata_o while not empty.
module cmd_fifo #(
  parameter int unsigned Width = 57,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push on a full FIFO is legal only alongside a pop; the caller gates it.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Queues incoming packets and dispatches them one at a time to the program or symbol engine,
// waiting for the matching done pulse or a timeout before launching the next command.
module cmd_scheduler
  import gp_pkg::*;
#(
  parameter int unsigned PKT_BITS       = DefPktBits,
  parameter int unsigned FIFO_DEPTH     = DefFifoDepth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                        i_clk,
  input  logic                        n_btn_rst,
  input  logic                        i_pkt_valid,
  input  logic                        i_pkt_sym,
  input  logic [PKT_BITS-1:0]         i_pkt_data,
  output logic [PKT_BITS-1:0]         o_cmd_data,
  output logic                        o_prog_start,
  output logic                        o_sym_start,
  input  logic                        i_prog_done,
  input  logic                        i_sym_done,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_overflow,
  output logic                        o_timeout,
  input  logic                        i_clr_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  sched_state_e        state_q;
  logic [PKT_BITS-1:0] cmd_data_q;
  logic                sym_flag_q;
  logic                prog_start_q;
  logic                sym_start_q;
  logic [TW-1:0]       tmo_cnt_q;
  logic                overflow_q, overflow_d;
  logic                timeout_q, timeout_d;

  logic                fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [PKT_BITS:0]   fifo_head;
  logic                eng_done, tmo_hit, overflow_set, timeout_set;

  assign fifo_pop     = (state_q == StIdle) && !fifo_empty;
  assign fifo_push    = i_pkt_valid && (!fifo_full || fifo_pop);
  assign overflow_set = i_pkt_valid && fifo_full && !fifo_pop;

  // Only the engine that was launched can end the dispatch.
  assign eng_done    = sym_flag_q ? i_sym_done : i_prog_done;
  assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_set = (state_q == StWaitDone) && !eng_done && tmo_hit;

  cmd_fifo #(
    .Width (PKT_BITS + 1),
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (i_clk),
    .rst_ni  (n_btn_rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({i_pkt_sym, i_pkt_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_fifo_count)
  );

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q      <= StIdle;
      cmd_data_q   <= '0;
      sym_flag_q   <= 1'b0;
      prog_start_q <= 1'b0;
      sym_start_q  <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      prog_start_q <= 1'b0;
      sym_start_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            cmd_data_q   <= fifo_head[PKT_BITS-1:0];
            sym_flag_q   <= fifo_head[PKT_BITS];
            // Start pulses are registered so they appear during LAUNCH.
            prog_start_q <= !fifo_head[PKT_BITS];
            sym_start_q  <= fifo_head[PKT_BITS];
            state_q      <= StLaunch;
          end
        end
        StLaunch: begin
          tmo_cnt_q <= '0;
          state_q   <= StWaitDone;
        end
        StWaitDone: begin
          if (eng_done || tmo_hit) begin
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Set takes priority over the synchronous clear.
  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (i_clr_err) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (overflow_set) overflow_d = 1'b1;
    if (timeout_set)  timeout_d  = 1'b1;
  end

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_cmd_data   = cmd_data_q;
  assign o_prog_start = prog_start_q;
  assign o_sym_start  = sym_start_q;
  assign o_busy       = (state_q != StIdle);
  assign o_overflow   = overflow_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: dispatch latency, engine selection, overflow, timeout, reset.
module tb_cmd_scheduler;

  localparam int unsigned PktBits = 56;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Tmo     = 16;

  logic               i_clk = 1'b0;
  logic               n_btn_rst;
  logic               i_pkt_valid;
  logic               i_pkt_sym;
  logic [PktBits-1:0] i_pkt_data;
  logic [PktBits-1:0] o_cmd_data;
  logic               o_prog_start;
  logic               o_sym_start;
  logic               i_prog_done;
  logic               i_sym_done;
  logic               o_busy;
  logic [2:0]         o_fifo_count;
  logic               o_overflow;
  logic               o_timeout;
  logic               i_clr_err;

  int n_chk  = 0;
  int n_fail = 0;

  cmd_scheduler #(
    .PKT_BITS       (PktBits),
    .FIFO_DEPTH     (Depth),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .i_clk        (i_clk),
    .n_btn_rst    (n_btn_rst),
    .i_pkt_valid  (i_pkt_valid),
    .i_pkt_sym    (i_pkt_sym),
    .i_pkt_data   (i_pkt_data),
    .o_cmd_data   (o_cmd_data),
    .o_prog_start (o_prog_start),
    .o_sym_start  (o_sym_start),
    .i_prog_done  (i_prog_done),
    .i_sym_done   (i_sym_done),
    .o_busy       (o_busy),
    .o_fifo_count (o_fifo_count),
    .o_overflow   (o_overflow),
    .o_timeout    (o_timeout),
    .i_clr_err    (i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_count"}, 64'(o_fifo_count), 64'd0);
    chk({tag, "_data"},  64'(o_cmd_data), 64'd0);
    chk({tag, "_pst"},   64'(o_prog_start), 64'd0);
    chk({tag, "_sst"},   64'(o_sym_start), 64'd0);
    chk({tag, "_ovf"},   64'(o_overflow), 64'd0);
    chk({tag, "_tmo"},   64'(o_timeout), 64'd0);
  endtask

  initial begin
    logic saw_start;
    n_btn_rst   = 1'b1;
    i_pkt_valid = 1'b0;
    i_pkt_sym   = 1'b0;
    i_pkt_data  = '0;
    i_prog_done = 1'b0;
    i_sym_done  = 1'b0;
    i_clr_err   = 1'b0;
    #1 n_btn_rst = 1'b0;
    #2;
    chk_reset_outputs("rst");
    repeat (2) tick();
    n_btn_rst = 1'b1;
    repeat (2) tick();

    // Program packet: start pulse two cycles after arrival, done releases busy next cycle.
    i_pkt_valid = 1'b1;
    i_pkt_sym   = 1'b0;
    i_pkt_data  = 56'h00112233445566;
    tick();
    i_pkt_valid = 1'b0;
    chk("t1_count_n1", 64'(o_fifo_count), 64'd1);
    chk("t1_pst_n1", 64'(o_prog_start), 64'd0);
    tick();
    chk("t1_pst_n2", 64'(o_prog_start), 64'd1);
    chk("t1_sst_n2", 64'(o_sym_start), 64'd0);
    chk("t1_data_n2", 64'(o_cmd_data), 64'h00112233445566);
    chk("t1_busy_n2", 64'(o_busy), 64'd1);
    tick();
    chk("t1_pst_n3", 64'(o_prog_start), 64'd0);
    repeat (7) tick();
    i_prog_done = 1'b1;
    tick();
    i_prog_done = 1'b0;
    chk("t1_busy_done", 64'(o_busy), 64'd0);
    chk("t1_data_hold", 64'(o_cmd_data), 64'h00112233445566);

    // Sym then prog back-to-back; a prog done during the sym dispatch is ignored.
    i_pkt_valid = 1'b1;
    i_pkt_sym   = 1'b1;
    i_pkt_data  = 56'hA5A5A5A5A5A5A5;
    tick();
    i_pkt_sym   = 1'b0;
    i_pkt_data  = 56'h0F0F0F0F0F0F0F;
    tick();
    i_pkt_valid = 1'b0;
    chk("t2_sst", 64'(o_sym_start), 64'd1);
    chk("t2_pst", 64'(o_prog_start), 64'd0);
    chk("t2_data_sym", 64'(o_cmd_data), 64'hA5A5A5A5A5A5A5);
    chk("t2_count", 64'(o_fifo_count), 64'd1);
    tick();
    tick();
    i_prog_done = 1'b1;
    tick();
    i_prog_done = 1'b0;
    chk("t2_busy_ignore", 64'(o_busy), 64'd1);
    chk("t2_pst_ignore", 64'(o_prog_start), 64'd0);
    tick();
    i_sym_done = 1'b1;
    tick();
    i_sym_done = 1'b0;
    chk("t2_busy_symdone", 64'(o_busy), 64'd0);
    tick();
    chk("t2_pst_second", 64'(o_prog_start), 64'd1);
    chk("t2_data_prog", 64'(o_cmd_data), 64'h0F0F0F0F0F0F0F);
    chk("t2_sst_second", 64'(o_sym_start), 64'd0);
    tick();
    i_prog_done = 1'b1;
    tick();
    i_prog_done = 1'b0;
    chk("t2_busy_end", 64'(o_busy), 64'd0);
    chk("t2_count_end", 64'(o_fifo_count), 64'd0);

    // Six packets while the engine is busy: queue fills to 4, the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      i_pkt_valid = 1'b1;
      i_pkt_sym   = 1'b0;
      i_pkt_data  = 56'(i + 1);
      if (i == 5) begin
        chk("t3_count_full", 64'(o_fifo_count), 64'd4);
        chk("t3_ovf_before", 64'(o_overflow), 64'd0);
      end
      tick();
    end
    i_pkt_valid = 1'b0;
    chk("t3_count_after", 64'(o_fifo_count), 64'd4);
    chk("t3_ovf_set", 64'(o_overflow), 64'd1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("t3_ovf_clr", 64'(o_overflow), 64'd0);
    tick();
    i_prog_done = 1'b1;
    tick();
    i_prog_done = 1'b0;
    // Queue full, FSM idle: push and pop in the same cycle.
    chk("t4_busy_idle", 64'(o_busy), 64'd0);
    i_pkt_valid = 1'b1;
    i_pkt_data  = 56'd7;
    tick();
    i_pkt_valid = 1'b0;
    chk("t4_count_same", 64'(o_fifo_count), 64'd4);
    chk("t4_ovf_zero", 64'(o_overflow), 64'd0);
    chk("t4_pst", 64'(o_prog_start), 64'd1);
    chk("t4_data", 64'(o_cmd_data), 64'd2);
    tick();
    i_prog_done = 1'b1;
    tick();
    i_prog_done = 1'b0;
    tick();
    chk("t5_pst", 64'(o_prog_start), 64'd1);
    chk("t5_data", 64'(o_cmd_data), 64'd3);
    chk("t5_count", 64'(o_fifo_count), 64'd3);
    tick();
    chk("t5_busy_wait", 64'(o_busy), 64'd1);
    chk("t5_count_wait", 64'(o_fifo_count), 64'd3);

    // Reset mid-dispatch with three queued.
    n_btn_rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    #2 n_btn_rst = 1'b1;
    saw_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw_start = saw_start | o_prog_start | o_sym_start;
    end
    chk("t5_no_start", 64'(saw_start), 64'd0);
    chk("t5_busy_post", 64'(o_busy), 64'd0);
    chk("t5_count_post", 64'(o_fifo_count), 64'd0);

    // Timeout on the first command, then the queued one launches.
    i_pkt_valid = 1'b1;
    i_pkt_sym   = 1'b0;
    i_pkt_data  = 56'hDEAD;
    tick();
    i_pkt_data  = 56'hBEEF;
    tick();
    i_pkt_valid = 1'b0;
    chk("t6_pst", 64'(o_prog_start), 64'd1);
    chk("t6_data", 64'(o_cmd_data), 64'hDEAD);
    repeat (16) tick();
    chk("t6_busy_last", 64'(o_busy), 64'd1);
    chk("t6_tmo_before", 64'(o_timeout), 64'd0);
    tick();
    chk("t6_busy_tmo", 64'(o_busy), 64'd0);
    chk("t6_tmo_set", 64'(o_timeout), 64'd1);
    chk("t6_count", 64'(o_fifo_count), 64'd1);
    tick();
    chk("t6_pst_next", 64'(o_prog_start), 64'd1);
    chk("t6_data_next", 64'(o_cmd_data), 64'hBEEF);
    i_prog_done = 1'b1;
    tick();
    i_prog_done = 1'b0;
    chk("t6_launch_done_ign", 64'(o_busy), 64'd1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("t6_tmo_clr", 64'(o_timeout), 64'd0);
    repeat (14) tick();
    // Done coincides with the last counted cycle.
    i_prog_done = 1'b1;
    tick();
    i_prog_done = 1'b0;
    chk("t7_busy", 64'(o_busy), 64'd0);
    chk("t7_tmo_not_set", 64'(o_timeout), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
